// File: rtl/memory_arbiter.sv
// memory_arbiter: serves instruction-fetch and data requests from the caches on one
// single-ported, variable-latency RAM. Data requests have priority. Each access is bounded by TIMEOUT cycles.
module memory_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int              CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX    = '1;
    localparam logic [1:0]      RAM_ACCESS = 2'd2;
    localparam logic [1:0]      RAM_ERROR  = 2'd3;
    localparam logic [31:0]     ERR_WORD   = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ram_ack, ram_fail, done;

    // ACCESS outranks the timeout when both land in the same cycle.
    assign ram_ack  = (ramstate == RAM_ACCESS);
    assign ram_fail = (ramstate == RAM_ERROR) || (cnt_q == CNT_LAST);
    assign done     = ram_ack || ram_fail;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output is defaulted first so no branch can infer a latch.
        state_d  = state_q;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_d = DSERV;
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end
            ISERV: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (done) begin
                        iwait   = 1'b0;
                        iload   = ram_ack ? ramload : ERR_WORD;
                        err     = !ram_ack;
                        state_d = IDLE;
                    end
                end
            end
            DSERV: begin
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN && !dWEN;
                    if (done) begin
                        dwait   = 1'b0;
                        dload   = !ram_ack ? ERR_WORD : (dWEN ? 32'h0 : ramload);
                        err     = !ram_ack;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: randomized cache traffic against a behavioural RAM,
// with expected responses queued by a transaction-level model and checked by a monitor.
module tb_memory_arbiter;
    localparam int          TO     = 4;
    localparam logic [1:0]  FREE   = 2'd0;
    localparam logic [1:0]  BUSY   = 2'd1;
    localparam logic [1:0]  ACC    = 2'd2;
    localparam logic [1:0]  ERR    = 2'd3;
    localparam logic [31:0] BADW   = 32'hBAD1_BAD1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_d;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          busy;
        logic [1:0]  outc;
        int          abort_after;
    } req_t;

    typedef struct {
        bit          is_d;
        logic [31:0] load;
        bit          err;
        int          lat;
        logic [31:0] addr;
        logic [31:0] store;
        bit          wen;
        bit          ren;
    } exp_t;

    typedef struct {
        int         busy;
        logic [1:0] outc;
    } plan_t;

    exp_t        sb[$];
    plan_t       plans[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ram_mem[32];
    int          n_checks = 0;
    int          n_err    = 0;
    int          svc_r    = 0;
    bit          mon_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2408_0001 : {a[15:0], ~a[15:0]};
    endfunction

    // Transaction-level expectation: outcome from the RAM's planned reply and the timeout rule.
    function automatic exp_t model(input req_t r);
        exp_t e;
        bit   ok;
        if ((r.outc == ACC || r.outc == ERR) && (r.busy + 1 <= TO)) begin
            e.lat = r.busy + 1;
            ok    = (r.outc == ACC);
        end else begin
            e.lat = TO;
            ok    = 1'b0;
        end
        e.is_d  = r.is_d;
        e.err   = !ok;
        e.addr  = r.addr;
        e.store = r.is_d ? r.data : 32'h0;
        e.wen   = r.is_d && r.wr;
        e.ren   = !(r.is_d && r.wr);
        if (!ok)
            e.load = BADW;
        else if (r.is_d && r.wr)
            e.load = 32'h0;
        else
            e.load = ref_mem.exists(r.addr) ? ref_mem[r.addr] : init_val(r.addr);
        if (ok && r.is_d && r.wr)
            ref_mem[r.addr] = r.data;
        return e;
    endfunction

    // Behavioural RAM: consecutive strobed cycles are counted; the planned reply lands after 'busy' cycles.
    assign ramload = ram_mem[ramaddr[6:2]];

    initial begin
        for (int k = 0; k < 8; k++) begin
            ram_mem[k]      = init_val(32'h100 + 32'(4 * k));
            ram_mem[16 + k] = init_val(32'h40 + 32'(4 * k));
        end
        ramstate = FREE;
        forever begin
            @(posedge CLK);
            #2;
            if (plans.size() == 0)
                ramstate = FREE;
            else if (svc_r == plans[0].busy)
                ramstate = plans[0].outc;
            else
                ramstate = BUSY;
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (ramWEN && ramstate == ACC)
                ram_mem[ramaddr[6:2]] = ramstore;
            if (ramREN || ramWEN) begin
                svc_r++;
            end else if (svc_r != 0) begin
                svc_r = 0;
                if (plans.size() != 0)
                    void'(plans.pop_front());
            end
        end
    end

    // Monitor: pops the scoreboard whenever a wait line drops and checks every cycle's invariants.
    initial begin
        int  svc_m = 0;
        bit  post_cmp = 0;
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            if (ramREN || ramWEN) svc_m++;
            else                  svc_m = 0;
            if (post_cmp)
                check("idle_after_completion", {ramREN, ramWEN, iwait, dwait}, 4'b0011);
            post_cmp = 0;
            if (iwait) check("iload_zero_when_waiting", iload, 32'h0);
            if (dwait) check("dload_zero_when_waiting", dload, 32'h0);
            if (!iwait || !dwait) begin
                post_cmp = 1;
                if (sb.size() == 0) begin
                    check("unexpected_completion", {iwait, dwait}, 2'b11);
                end else begin
                    e = sb.pop_front();
                    check("owner", {iwait, dwait}, e.is_d ? 2'b10 : 2'b01);
                    check("load", e.is_d ? dload : iload, e.load);
                    check("err", err, e.err);
                    check("latency", svc_m, e.lat);
                    check("ramaddr", ramaddr, e.addr);
                    check("ramstore", ramstore, e.store);
                    check("strobes", {ramWEN, ramREN}, {e.wen, e.ren});
                end
            end else begin
                check("err_without_completion", err, 1'b0);
            end
        end
    end

    task automatic apply(input req_t r);
        if (r.is_d) begin
            dWEN = r.wr; dREN = r.rd; daddr = r.addr; dstore = r.data;
        end else begin
            iREN = 1'b1; iaddr = r.addr;
        end
    endtask

    task automatic release_req(input bit is_d);
        if (is_d) begin
            dWEN = 1'b0; dREN = 1'b0;
        end else begin
            iREN = 1'b0;
        end
    endtask

    task automatic issue(input req_t r);
        plan_t p;
        p.busy = r.busy;
        p.outc = r.outc;
        plans.push_back(p);
        if (r.abort_after == 0) sb.push_back(model(r));
    endtask

    task automatic run_single(input req_t r);
        bit done = 0;
        issue(r);
        @(posedge CLK); #1;
        apply(r);
        if (r.abort_after != 0) begin
            repeat (r.abort_after + 1) @(posedge CLK);
            #1;
            release_req(r.is_d);
            @(negedge CLK);
            check("abort_idle", {ramREN, ramWEN, iwait, dwait, err}, 5'b00110);
        end else begin
            for (int c = 0; c < 64 && !done; c++) begin
                @(negedge CLK);
                done = r.is_d ? !dwait : !iwait;
            end
            check("single_done", done, 1'b1);
            @(posedge CLK); #1;
            release_req(r.is_d);
        end
    endtask

    task automatic run_pair(input req_t d, input req_t i);
        bit d_done = 0, i_done = 0, d_now, i_now;
        issue(d);
        issue(i);
        @(posedge CLK); #1;
        apply(d);
        apply(i);
        for (int c = 0; c < 64 && !(d_done && i_done); c++) begin
            @(negedge CLK);
            d_now = !dwait;
            i_now = !iwait;
            @(posedge CLK); #1;
            if (d_now) begin release_req(1'b1); d_done = 1; end
            if (i_now) begin release_req(1'b0); i_done = 1; end
        end
        check("pair_done", {d_done, i_done}, 2'b11);
    endtask

    function automatic req_t mk(input bit is_d, input bit wr, input bit rd, input logic [31:0] addr,
                                input logic [31:0] data, input int busy, input logic [1:0] outc,
                                input int abort_after);
        req_t r;
        r.is_d = is_d; r.wr = wr; r.rd = rd; r.addr = addr; r.data = data;
        r.busy = busy; r.outc = outc; r.abort_after = abort_after;
        return r;
    endfunction

    function automatic req_t rand_req(input bit is_d);
        int m = $urandom_range(0, 2);
        int p = $urandom_range(0, 9);
        logic [1:0] o = (p < 7) ? ACC : ((p < 9) ? ERR : BUSY);
        logic [31:0] a = is_d ? 32'h100 + 32'(4 * $urandom_range(0, 7))
                              : 32'h40 + 32'(4 * $urandom_range(0, 7));
        return mk(is_d, is_d && m != 0, !is_d || m != 1, a, $urandom, $urandom_range(0, 5), o, 0);
    endfunction

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        summary();
        $finish;
    end

    initial begin
        req_t r, d;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_waits", {iwait, dwait}, 2'b11);
        check("rst_loads", {iload, dload}, 64'h0);
        check("rst_strobes", {ramREN, ramWEN, err}, 3'b000);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        mon_en = 1;
        repeat (3) begin
            @(negedge CLK);
            check("idle_no_strobes", {ramREN, ramWEN}, 2'b00);
        end

        // Instruction fetch after two BUSY cycles.
        run_single(mk(0, 0, 1, 32'h40, 32'h0, 2, ACC, 0));
        // Data write and instruction fetch arriving together, zero-wait RAM.
        run_pair(mk(1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, ACC, 0), mk(0, 0, 1, 32'h44, 32'h0, 0, ACC, 0));
        // dREN and dWEN together behave as a write.
        run_single(mk(1, 1, 1, 32'h104, 32'h1234_5678, 0, ACC, 0));
        // Read back both writes.
        run_single(mk(1, 0, 1, 32'h100, 32'h0, 1, ACC, 0));
        run_single(mk(1, 0, 1, 32'h104, 32'h0, 0, ACC, 0));
        // Timeout on a data read, ERROR on cycle 2, ACCESS exactly at the timeout cycle.
        run_single(mk(1, 0, 1, 32'h108, 32'h0, 9, BUSY, 0));
        run_single(mk(1, 0, 1, 32'h10C, 32'h0, 1, ERR, 0));
        run_single(mk(0, 0, 1, 32'h48, 32'h0, TO - 1, ACC, 0));
        // Instruction fetch dropped after one service cycle.
        run_single(mk(0, 0, 1, 32'h4C, 32'h0, TO + 2, BUSY, 1));

        // Reset during a data access abandons it.
        d = mk(1, 0, 1, 32'h110, 32'h0, TO + 2, BUSY, 0);
        issue(d);
        void'(sb.pop_back());
        @(posedge CLK); #1;
        apply(d);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        release_req(1'b1);
        @(negedge CLK);
        check("midrst_outputs", {iwait, dwait, ramREN, ramWEN, err}, 5'b11000);
        check("midrst_ramaddr", ramaddr, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int t = 0; t < 150; t++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 9) begin
                run_pair(rand_req(1), rand_req(0));
            end else begin
                r = rand_req(kind >= 4);
                if (kind == 8) begin
                    r.busy = TO + 2;
                    r.outc = BUSY;
                    r.abort_after = $urandom_range(1, TO - 2);
                end
                run_single(r);
            end
        end

        repeat (5) @(posedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        summary();
        $finish;
    end
endmodule
